// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage unit. Single-cycle base integer ALU ops plus the
// RV32M multiply/divide family. Multiply and divide use iterative radix-2
// shift-add and restoring-divide datapaths, one bit per cycle. While one of
// them runs, the unit holds o_ready low.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_opsel,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  localparam int CW = (SHW > 5) ? SHW : 5;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;

  // Iteration state, shared by multiply and divide.
  // Multiply: acc = {partial product high, remaining multiplier bits}, opb = multiplicand.
  // Divide:   acc = {partial remainder, dividend/quotient bits},       opb = divisor.
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN-1:0]   op1_q;
  logic [1:0]        fn_q;
  logic              neg_q;
  logic              negr_q;
  logic              div0_q;
  logic              ovf_q;

  logic              accept;
  logic              is_mul;
  logic              is_div;
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   base_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_d;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_d;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   fin_res;

  // Single-cycle base operations; unlisted encodings yield zero.
  function automatic logic [XLEN-1:0] base_op(input logic [4:0]      op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      5'h00:   return a + b;
      5'h01:   return a - b;
      5'h02:   return a << sh;
      5'h03:   return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      5'h04:   return {{(XLEN-1){1'b0}}, (a < b)};
      5'h05:   return a ^ b;
      5'h06:   return a >> sh;
      5'h07:   return $unsigned($signed(a) >>> sh);
      5'h08:   return a | b;
      5'h09:   return a & b;
      5'h0A:   return b;
      default: return '0;
    endcase
  endfunction

  assign o_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;
  assign o_zero   = zero_q;

  // Decode the request: operation class, operand signedness and magnitudes.
  always_comb begin
    accept   = i_valid & o_ready;
    is_mul   = (i_opsel[4:2] == 3'b100);
    is_div   = (i_opsel[4:2] == 3'b101);
    // MUL low half is sign-agnostic, so it runs unsigned.
    a_sgn    = (is_mul & ((i_opsel[1:0] == 2'b01) | (i_opsel[1:0] == 2'b10))) |
               (is_div & ~i_opsel[0]);
    b_sgn    = (is_mul & (i_opsel[1:0] == 2'b01)) | (is_div & ~i_opsel[0]);
    a_neg    = a_sgn & i_op1[XLEN-1];
    b_neg    = b_sgn & i_op2[XLEN-1];
    a_mag    = a_neg ? ('0 - i_op1) : i_op1;
    b_mag    = b_neg ? ('0 - i_op2) : i_op2;
    base_res = base_op(i_opsel, i_op1, i_op2);
  end

  // One multiply step and one divide step, plus the sign fix-up of the final step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q & {XLEN{acc_q[0]}}};
    mul_d    = {mul_sum, acc_q[XLEN-1:1]};
    prod     = neg_q ? ('0 - mul_d) : mul_d;
    mul_res  = (fn_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opb_q});
    // The true difference is below the divisor whenever it is used, so it fits XLEN bits.
    div_diff = div_sh[XLEN-1:0] - opb_q;
    div_d    = {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    quo      = neg_q  ? ('0 - div_d[XLEN-1:0])      : div_d[XLEN-1:0];
    rem      = negr_q ? ('0 - div_d[2*XLEN-1:XLEN]) : div_d[2*XLEN-1:XLEN];
    if (div0_q) begin
      quo = '1;
      rem = op1_q;
    end else if (ovf_q) begin
      quo = op1_q;
      rem = '0;
    end
    div_res  = fn_q[1] ? rem : quo;
    fin_res  = (state_q == S_MUL) ? mul_res : div_res;
  end

  // Iterative datapath: load magnitudes and flags at accept, step while busy.
  always_ff @(posedge i_clk) begin
    if (accept && (is_mul || is_div)) begin
      acc_q  <= {{XLEN{1'b0}}, (is_mul ? b_mag : a_mag)};
      opb_q  <= is_mul ? a_mag : b_mag;
      op1_q  <= i_op1;
      fn_q   <= i_opsel[1:0];
      neg_q  <= a_neg ^ b_neg;
      negr_q <= a_neg;
      div0_q <= is_div & (i_op2 == '0);
      ovf_q  <= is_div & ~i_opsel[0] & (i_op1 == MIN_NEG) & (i_op2 == '1);
    end else if (state_q == S_MUL) begin
      acc_q  <= mul_d;
    end else if (state_q == S_DIV) begin
      acc_q  <= div_d;
    end
  end

  // Control FSM with registered result and zero flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state_q)
        S_MUL, S_DIV: begin
          if (cnt_q == '0) begin
            state_q  <= S_DONE;
            result_q <= fin_res;
            zero_q   <= (fin_res == '0);
          end else begin
            cnt_q    <= cnt_q - CW'(1);
          end
        end
        default: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= S_MUL;
              cnt_q   <= CW'(XLEN - 1);
            end else if (is_div) begin
              state_q <= S_DIV;
              cnt_q   <= CW'(XLEN - 1);
            end else begin
              state_q  <= S_DONE;
              result_q <= base_res;
              zero_q   <= (base_res == '0);
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: directed and randomized operations checked against
// a plain-arithmetic reference model, plus handshake, stall and reset scenarios.
module tb_alu_mdu;
  localparam int XLEN = 32;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_opsel;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_zero;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.XLEN(XLEN)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_opsel (i_opsel),
    .i_op1   (i_op1),
    .i_op2   (i_op2),
    .o_valid (o_valid),
    .o_result(o_result),
    .o_zero  (o_zero)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: RISC-V semantics with 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          p;
    longint unsigned up;
    int              ia;
    int              ib;
    logic            ovf;
    ia  = int'(a);
    ib  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return a << b[4:0];
      5'h03: return (ia < ib) ? 32'd1 : 32'd0;
      5'h04: return (a < b) ? 32'd1 : 32'd0;
      5'h05: return a ^ b;
      5'h06: return a >> b[4:0];
      5'h07: return 32'(ia >>> b[4:0]);
      5'h08: return a | b;
      5'h09: return a & b;
      5'h0A: return b;
      5'h10: return a * b;
      5'h11: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
      5'h12: begin p = longint'(ia) * longint'({32'd0, b}); return p[63:32]; end
      5'h13: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      5'h14: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      5'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'h16: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      5'h17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request and wait (bounded) for its o_valid; inputs are scrambled while busy.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output int busy);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_opsel = op;
    i_op1   = a;
    i_op2   = b;
    @(negedge i_clk);
    i_valid = 1'b0;
    lat  = 1;
    busy = 0;
    while (o_valid !== 1'b1 && lat < 200) begin
      if (o_ready === 1'b0) busy++;
      i_opsel = 5'($urandom);
      i_op1   = $urandom;
      i_op2   = $urandom;
      @(negedge i_clk);
      lat++;
    end
    res = o_result;
    z   = o_zero;
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_opsel = 5'd0;
    i_op1   = 32'd0;
    i_op2   = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", o_result); end
    checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", o_zero); end
    i_rst = 1'b0;
  endtask

  task automatic test_base_directed();
    logic [4:0]  ops[5] = '{5'h00, 5'h01, 5'h07, 5'h03, 5'h04};
    logic [31:0] as[5]  = '{32'd7, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs[5]  = '{32'd5, 32'd5, 32'd4, 32'd1, 32'd1};
    logic [31:0] ex[5]  = '{32'd12, 32'd0, 32'hF800_0000, 32'd1, 32'd0};
    logic [31:0] res;
    logic        z;
    int          lat;
    int          busy;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], res, z, lat, busy);
      checks++; if (res !== ex[i]) begin errors++; $display("FAIL base_dir[%0d] result: got %h expected %h", i, res, ex[i]); end
      checks++; if (z !== (ex[i] == 0)) begin errors++; $display("FAIL base_dir[%0d] zero: got %b expected %b", i, z, ex[i] == 0); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL base_dir[%0d] latency: got %0d expected 1", i, lat); end
    end
  endtask

  task automatic test_base_random();
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ex;
    logic [31:0] res;
    logic        z;
    int          lat;
    int          busy;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op[4:3] == 2'b10) op = op & 5'h0F;
      a  = $urandom;
      b  = (i % 5 == 0) ? a : $urandom;
      ex = model(op, a, b);
      run_op(op, a, b, res, z, lat, busy);
      checks++; if (res !== ex) begin errors++; $display("FAIL base_rand[%0d] op=%h result: got %h expected %h", i, op, res, ex); end
      checks++; if (z !== (ex == 0)) begin errors++; $display("FAIL base_rand[%0d] zero: got %b expected %b", i, z, ex == 0); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL base_rand[%0d] latency: got %0d expected 1", i, lat); end
    end
  endtask

  task automatic test_muldiv_directed();
    logic [4:0]  ops[12] = '{5'h10, 5'h11, 5'h13, 5'h12, 5'h14, 5'h16, 5'h15, 5'h17,
                             5'h14, 5'h16, 5'h15, 5'h17};
    logic [31:0] as[12]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
    logic [31:0] bs[12]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd7, 32'd7,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] ex[12]  = '{32'd1, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9};
    logic [31:0] res;
    logic        z;
    int          lat;
    int          busy;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], res, z, lat, busy);
      checks++; if (res !== ex[i]) begin errors++; $display("FAIL md_dir[%0d] op=%h result: got %h expected %h", i, ops[i], res, ex[i]); end
      checks++; if (z !== (ex[i] == 0)) begin errors++; $display("FAIL md_dir[%0d] zero: got %b expected %b", i, z, ex[i] == 0); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL md_dir[%0d] latency: got %0d expected 33", i, lat); end
      checks++; if (busy !== 32) begin errors++; $display("FAIL md_dir[%0d] busy_cycles: got %0d expected 32", i, busy); end
    end
  endtask

  task automatic test_muldiv_random();
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ex;
    logic [31:0] res;
    logic        z;
    int          lat;
    int          busy;
    for (int i = 0; i < 40; i++) begin
      op = 5'h10 + 5'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      ex = model(op, a, b);
      run_op(op, a, b, res, z, lat, busy);
      checks++; if (res !== ex) begin errors++; $display("FAIL md_rand[%0d] op=%h a=%h b=%h result: got %h expected %h", i, op, a, b, res, ex); end
      checks++; if (z !== (ex == 0)) begin errors++; $display("FAIL md_rand[%0d] zero: got %b expected %b", i, z, ex == 0); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL md_rand[%0d] latency: got %0d expected 33", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0 = $urandom;
    logic [31:0] b0 = $urandom;
    logic [31:0] a1 = $urandom;
    logic [31:0] b1 = 32'($urandom_range(1, 1000));
    logic [31:0] a2 = $urandom;
    logic [31:0] b2 = $urandom;
    int          pulses = 0;
    int          ready_hi = 0;
    int          cyc;
    @(negedge i_clk);
    i_valid = 1'b1; i_opsel = 5'h00; i_op1 = a0; i_op2 = b0;
    @(negedge i_clk);
    if (o_valid === 1'b1) pulses++;
    checks++; if (o_valid !== 1'b1 || o_result !== a0 + b0) begin errors++; $display("FAIL b2b_add: got valid=%b result=%h expected valid=1 result=%h", o_valid, o_result, a0 + b0); end
    i_opsel = 5'h14; i_op1 = a1; i_op2 = b1;
    @(negedge i_clk);
    i_opsel = 5'h05; i_op1 = a2; i_op2 = b2;
    cyc = 1;
    while (o_valid !== 1'b1 && cyc < 100) begin
      if (o_ready !== 1'b0) ready_hi++;
      @(negedge i_clk);
      cyc++;
    end
    if (o_valid === 1'b1) pulses++;
    checks++; if (ready_hi !== 0) begin errors++; $display("FAIL b2b_stall_ready: got %0d ready cycles during DIV expected 0", ready_hi); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_div_latency: got %0d expected 33", cyc); end
    checks++; if (o_result !== model(5'h14, a1, b1)) begin errors++; $display("FAIL b2b_div_result: got %h expected %h", o_result, model(5'h14, a1, b1)); end
    @(negedge i_clk);
    if (o_valid === 1'b1) pulses++;
    checks++; if (o_valid !== 1'b1 || o_result !== (a2 ^ b2)) begin errors++; $display("FAIL b2b_xor: got valid=%b result=%h expected valid=1 result=%h", o_valid, o_result, a2 ^ b2); end
    i_valid = 1'b0;
    @(negedge i_clk);
    if (o_valid === 1'b1) pulses++;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
  endtask

  task automatic test_reset_mid();
    int          pulses = 0;
    logic [31:0] res;
    logic        z;
    int          lat;
    int          busy;
    @(negedge i_clk);
    i_valid = 1'b1; i_opsel = 5'h10; i_op1 = 32'd3; i_op2 = 32'd5;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", o_ready); end
    checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h expected 0", o_result); end
    checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL midrst_zero: got %b expected 1", o_zero); end
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_stale_valid: got %0d pulses expected 0", pulses); end
    run_op(5'h00, 32'd1, 32'd1, res, z, lat, busy);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL midrst_add_result: got %h expected 2", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL midrst_add_latency: got %0d expected 1", lat); end
  endtask

  initial begin
    test_reset();
    test_base_directed();
    test_base_random();
    test_muldiv_directed();
    test_muldiv_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute unit: all base integer ALU operations plus the RV32M multiply/divide family. Width is set by `XLEN`, and operands are accepted through a valid/ready handshake. Base operations complete in one cycle. Multiply and divide run on iterative shift-add/subtract datapaths with a fixed latency. It sits in the execute stage and stalls the pipeline through `o_ready` while a multi-cycle operation is in flight.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two, ≥ 8.
- `SHW`, $clog2(XLEN): shift-amount width (derived; do not override).

- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  operation request; sampled only when `o_ready`=1.
- `o_ready`  out  1  unit can accept a request this cycle.
- `i_opsel`  in  5  operation select (encoding below).
- `i_op1`  in  XLEN  first operand / dividend / multiplicand.
- `i_op2`  in  XLEN  second operand / divisor / multiplier.
- `o_valid`  out  1  `o_result`/`o_zero` valid; one-cycle pulse per accepted request.
- `o_result`  out  XLEN  registered result.
- `o_zero`  out  1  registered; 1 when `o_result` == 0.

## Operation
- **Base encodings** (5'h00–5'h0A):
  - 00 ADD, 01 SUB, 02 SLL, 03 SLT (signed), 04 SLTU, 05 XOR.
  - 06 SRL, 07 SRA, 08 OR, 09 AND, 0A PASS (result = op2).
  - Shifts use `op2[SHW-1:0]`. SLT/SLTU return 1 or 0, zero-extended.
- **M encodings** (5'h10–5'h17): 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
- **Unlisted encodings**: treated as a base op with result 0 (latency 1).
- **State machine**: IDLE, MUL, DIV, DONE.
  - IDLE/DONE + accept (`i_valid` & `o_ready`):
    - base op: compute, register result → DONE.
    - 10–13 → MUL.
    - 14–17 → DIV.
  - IDLE/DONE, no accept → IDLE.
  - MUL/DIV: 5-bit-or-wider counter `cnt` loaded with XLEN−1 at accept, decrements each cycle; at `cnt`==0 → DONE.
- **Multiply**:
  - Operands are converted to magnitude, with sign recorded per op. Signed: MULH both operands; MULHSU op1 only.
  - Datapath: 2·XLEN product register, radix-2 shift-add, one multiplier bit per cycle.
  - Final product is negated if signs differ.
  - MUL returns `product[XLEN-1:0]`; MULH/MULHSU/MULHU return `product[2XLEN-1:XLEN]`.
- **Divide**:
  - Datapath: restoring, one quotient bit per cycle, on magnitudes.
  - Sign fix: quotient is negative if operand signs differ (DIV only). Remainder takes the dividend's sign (REM only).
  - Divide by zero (detected at accept; iterations still run and are discarded):
    - quotient = all ones;
    - remainder = op1.
  - Signed overflow (op1 = most negative, op2 = −1, DIV/REM):
    - quotient = op1;
    - remainder = 0.
- **`o_ready`** = 1 in IDLE and DONE; 0 in MUL and DIV. This allows back-to-back issue.
- **`o_valid`** = 1 exactly in DONE.
- **`o_result`/`o_zero`**: updated only on entry to DONE; held until the next DONE.
- **Operands**: captured at accept. Input changes during MUL/DIV have no effect.

## Timing
- Accept at edge N.
  - Base op: `o_valid` high in cycle N+1 (latency 1).
  - M op: `o_valid` high in cycle N+XLEN+1 (latency XLEN+1, fixed, including div-by-zero/overflow). 32 cycles busy for XLEN=32.
- Back-to-back: an accept in the DONE cycle starts the next op. The next `o_valid` follows at the same latency, so base ops sustain one result per cycle.
- Reset (any state, including mid-MUL/DIV):
  - next cycle state = IDLE, `o_valid`=0, `o_ready`=1;
  - `o_result`=0, `o_zero`=1, `cnt`=0;
  - the in-flight op is discarded; no `o_valid` is produced for it.
- `i_valid` while `o_ready`=0 is ignored, not queued.
- `o_zero` is coincident with `o_result`.

## Test plan
- **Reset/base ops**: reset, then ADD 7+5 → `o_valid` next cycle, result 12, `o_zero`=0. SUB 5−5 → 0, `o_zero`=1. SRA 0x80000000>>>4 → 0xF8000000. SLT −1<1 → 1; SLTU → 0.
- **Multiply**: MUL 0xFFFFFFFF×0xFFFFFFFF → 1. MULH → 0. MULHU → 0xFFFFFFFE. MULHSU(−1, 0xFFFFFFFF) → 0xFFFFFFFF. `o_valid` exactly 33 cycles after accept; `o_ready`=0 for cycles N+1..N+32.
- **Divide**: DIV −7/2 → −3 (0xFFFFFFFD). REM −7/2 → −1. DIVU 100/7 → 14. REMU → 2.
- **Divide corner cases**: DIV 0x80000000/−1 → 0x80000000, REM → 0. DIVU 9/0 → 0xFFFFFFFF. REMU 9/0 → 9. Each at latency 33.
- **Back-to-back and stall**: accept ADD, then DIV issued in the DONE cycle, then XOR held on `i_valid` during DIV. Required: XOR is not accepted until DIV's DONE cycle, and exactly three `o_valid` pulses occur in order.
- **Reset mid-operation**: assert `i_rst` at cycle 10 of a MUL → `o_valid` never pulses for it, `o_result`=0, `o_ready`=1 next cycle. A fresh ADD 1+1 then returns 2.
